// File: rtl/operand_fetch_decode_pkg.sv
// Shared definitions for the decode/operand-fetch stage: opcode constants,
// RV32 instruction field positions and the decoded-field / pipeline-slot types.
package operand_fetch_decode_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int NREG_DEFAULT = 32;
   localparam int REG_IDX_W    = 5;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;

   localparam int OPCODE_MSB = 6;
   localparam int OPCODE_LSB = 0;
   localparam int RD_MSB     = 11;
   localparam int RD_LSB     = 7;
   localparam int FUNCT3_MSB = 14;
   localparam int FUNCT3_LSB = 12;
   localparam int RS1_MSB    = 19;
   localparam int RS1_LSB    = 15;
   localparam int RS2_MSB    = 24;
   localparam int RS2_LSB    = 20;
   localparam int FUNCT7_MSB = 31;
   localparam int FUNCT7_LSB = 25;

   typedef struct packed {
      logic [6:0]           opcode;
      logic [6:0]           funct7;
      logic [2:0]           funct3;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rd;
   } instr_fields_t;

   // Control part of an S1/S2 slot; an all-zero value is a bubble.
   typedef struct packed {
      logic [6:0]           funct7;
      logic [2:0]           funct3;
      logic [REG_IDX_W-1:0] rd;
      logic                 rd_valid;
   } slot_ctrl_t;

   function automatic instr_fields_t decode_fields(input logic [31:0] instr);
      instr_fields_t f;
      f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
      f.funct7 = instr[FUNCT7_MSB:FUNCT7_LSB];
      f.funct3 = instr[FUNCT3_MSB:FUNCT3_LSB];
      f.rs1    = instr[RS1_MSB:RS1_LSB];
      f.rs2    = instr[RS2_MSB:RS2_LSB];
      f.rd     = instr[RD_MSB:RD_LSB];
      return f;
   endfunction

endpackage

// File: rtl/operand_fetch_decode_if.sv
// Instruction handshake plus ALU-facing outputs of the decode stage.
// The stage itself uses the slave modport; upstream/ALU side uses master.
interface operand_fetch_decode_if #(
   parameter int XLEN = operand_fetch_decode_pkg::XLEN_DEFAULT
);
   import operand_fetch_decode_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          INSTR;
   logic [6:0]           OPCODE;
   logic [6:0]           FUNC7;
   logic [2:0]           FUNC3;
   logic [XLEN-1:0]      OP1;
   logic [XLEN-1:0]      OP2;
   logic [REG_IDX_W-1:0] RD;
   logic                 RD_VALID;
   logic                 illegal;

   modport master (
      output in_valid, INSTR,
      input  in_ready, OPCODE, FUNC7, FUNC3, OP1, OP2, RD, RD_VALID, illegal
   );

   modport slave (
      input  in_valid, INSTR,
      output in_ready, OPCODE, FUNC7, FUNC3, OP1, OP2, RD, RD_VALID, illegal
   );

endinterface

// File: rtl/operand_fetch_decode_reg_file.sv
// Integer register file: two combinational read ports with write-first bypass,
// one write port, x0 hardwired to zero, cleared by synchronous reset.
module operand_fetch_decode_reg_file
   import operand_fetch_decode_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREG = NREG_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] rs1_addr,
   input  logic [REG_IDX_W-1:0] rs2_addr,
   output logic [XLEN-1:0]      rs1_data,
   output logic [XLEN-1:0]      rs2_data,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] wr_addr,
   input  logic [XLEN-1:0]      wr_data
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // A write landing this cycle is visible to the reader immediately.
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == '0) begin
         rs1_data = '0;
      end else if (we && wr_addr == rs1_addr) begin
         rs1_data = wr_data;
      end
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      if (rs2_addr == '0) begin
         rs2_data = '0;
      end else if (we && wr_addr == rs2_addr) begin
         rs2_data = wr_data;
      end
   end

endmodule

// File: rtl/operand_fetch_decode.sv
// Decode and operand-fetch stage ahead of the ALU: busy-bit hazard blocking,
// operand read with writeback bypass, and the one-cycle opcode lead (S1 -> S2).
module operand_fetch_decode
   import operand_fetch_decode_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREG = NREG_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   operand_fetch_decode_if.slave bus,
   input  logic                 flush,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_data
);

   instr_fields_t   f;
   logic            is_rtype;
   logic            in_ready;
   logic            accept;
   logic            issue;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_clr;
   logic [NREG-1:0] busy_set;
   logic [NREG-1:0] busy_eff;
   logic [6:0]      s1_opcode;
   slot_ctrl_t      s1_ctrl;
   slot_ctrl_t      s2_ctrl;
   logic [XLEN-1:0] s1_op1;
   logic [XLEN-1:0] s1_op2;
   logic [XLEN-1:0] s2_op1;
   logic [XLEN-1:0] s2_op2;
   logic            illegal_q;

   assign f        = decode_fields(bus.INSTR);
   assign is_rtype = (f.opcode == OP_RTYPE);

   always_comb begin
      busy_clr = '0;
      if (wb_en) begin
         busy_clr[wb_rd] = 1'b1;
      end
   end

   // A register whose writeback arrives this cycle no longer blocks issue.
   assign busy_eff = busy & ~busy_clr;
   assign in_ready = ~rst & ~flush & ~busy_eff[f.rs1] & ~busy_eff[f.rs2] & ~busy_eff[f.rd];
   assign accept   = bus.in_valid & in_ready;
   assign issue    = accept & is_rtype;

   always_comb begin
      busy_set = '0;
      if (issue && f.rd != '0) begin
         busy_set[f.rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~busy_clr) | busy_set;
      end
   end

   operand_fetch_decode_reg_file #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (f.rs1),
      .rs2_addr (f.rs2),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .we       (wb_en),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   // Non-R-type instructions are consumed but leave a bubble; rd_valid marks
   // only slots that actually write a register (x0 is not a real writer).
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         s1_opcode <= '0;
         s1_ctrl   <= '0;
         s1_op1    <= '0;
         s1_op2    <= '0;
         s2_ctrl   <= '0;
         s2_op1    <= '0;
         s2_op2    <= '0;
         illegal_q <= 1'b0;
      end else begin
         s2_ctrl   <= s1_ctrl;
         s2_op1    <= s1_op1;
         s2_op2    <= s1_op2;
         illegal_q <= accept & ~is_rtype;
         if (issue) begin
            s1_opcode        <= f.opcode;
            s1_ctrl.funct7   <= f.funct7;
            s1_ctrl.funct3   <= f.funct3;
            s1_ctrl.rd       <= f.rd;
            s1_ctrl.rd_valid <= (f.rd != '0);
            s1_op1           <= rs1_data;
            s1_op2           <= rs2_data;
         end else begin
            s1_opcode <= '0;
            s1_ctrl   <= '0;
            s1_op1    <= '0;
            s1_op2    <= '0;
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.OPCODE   = s1_opcode;
   assign bus.FUNC7    = s2_ctrl.funct7;
   assign bus.FUNC3    = s2_ctrl.funct3;
   assign bus.OP1      = s2_op1;
   assign bus.OP2      = s2_op2;
   assign bus.RD       = s2_ctrl.rd;
   assign bus.RD_VALID = s2_ctrl.rd_valid;
   assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_operand_fetch_decode.sv
// Self-checking bench for operand_fetch_decode: directed vector table, reset
// sequences, then randomized traffic against an instruction-level model.
module tb_operand_fetch_decode;

   localparam logic [6:0] R      = 7'b0110011;
   localparam logic [6:0] F7_ADD = 7'h00;
   localparam logic [6:0] F7_SUB = 7'h20;
   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_XOR = 3'd4;
   localparam logic [2:0] F3_AND = 3'd7;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        in_valid;
      logic [31:0] instr;
      logic        wb_en;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        exp_ready;
      logic [6:0]  exp_opcode;
      logic [6:0]  exp_func7;
      logic [2:0]  exp_func3;
      logic [31:0] exp_op1;
      logic [31:0] exp_op2;
      logic [4:0]  exp_rd;
      logic        exp_rd_valid;
      logic        exp_illegal;
   } vec_t;

   typedef struct {
      logic [6:0]  func7;
      logic [2:0]  func3;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rd_valid;
   } alu_slot_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_checks;
   int n_fails;

   operand_fetch_decode_if #(.XLEN(32)) bus ();

   operand_fetch_decode #(
      .XLEN (32),
      .NREG (32)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .flush   (flush),
      .wb_en   (wb_en),
      .wb_rd   (wb_rd),
      .wb_data (wb_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] rtypeInstr(input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, R};
   endfunction

   function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic wbe,
                               input logic [4:0] wbr, input logic [31:0] wbd, input logic fl,
                               input logic rdy, input logic [6:0] opc, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [31:0] o1, input logic [31:0] o2,
                               input logic [4:0] rd, input logic rdv, input logic ill);
      vec_t t;
      t.rst = 1'b0;          t.flush = fl;          t.in_valid = v;
      t.instr = instr;       t.wb_en = wbe;         t.wb_rd = wbr;
      t.wb_data = wbd;       t.exp_ready = rdy;     t.exp_opcode = opc;
      t.exp_func7 = f7;      t.exp_func3 = f3;      t.exp_op1 = o1;
      t.exp_op2 = o2;        t.exp_rd = rd;         t.exp_rd_valid = rdv;
      t.exp_illegal = ill;
      return t;
   endfunction

   function automatic vec_t mkReset();
      vec_t t;
      t = mk(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 7'h0, 7'h0, 3'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      t.rst = 1'b1;
      return t;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs mid-period and check the combinational ready.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst          = v.rst;
      flush        = v.flush;
      wb_en        = v.wb_en;
      wb_rd        = v.wb_rd;
      wb_data      = v.wb_data;
      bus.in_valid = v.in_valid;
      bus.INSTR    = v.instr;
      #1;
      checkValue("in_ready", {31'b0, bus.in_ready}, {31'b0, v.exp_ready});
   endtask

   task automatic checkOutput(input vec_t v);
      @(posedge clk);
      #1;
      checkValue("OPCODE",   {25'b0, bus.OPCODE},   {25'b0, v.exp_opcode});
      checkValue("FUNC7",    {25'b0, bus.FUNC7},    {25'b0, v.exp_func7});
      checkValue("FUNC3",    {29'b0, bus.FUNC3},    {29'b0, v.exp_func3});
      checkValue("OP1",      bus.OP1,               v.exp_op1);
      checkValue("OP2",      bus.OP2,               v.exp_op2);
      checkValue("RD",       {27'b0, bus.RD},       {27'b0, v.exp_rd});
      checkValue("RD_VALID", {31'b0, bus.RD_VALID}, {31'b0, v.exp_rd_valid});
      checkValue("illegal",  {31'b0, bus.illegal},  {31'b0, v.exp_illegal});
   endtask

   // Instruction-level reference: architectural registers, pending writers,
   // and the instruction issued one cycle ago (which is what the ALU sees now).
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   alu_slot_t   m_prev;

   function automatic logic mBlocked(input logic [4:0] r, input vec_t v);
      return m_busy[r] && !(v.wb_en && v.wb_rd == r);
   endfunction

   function automatic logic [31:0] mRead(input logic [4:0] r, input vec_t v);
      if (r == 5'd0) return 32'h0;
      if (v.wb_en && v.wb_rd == r) return v.wb_data;
      return m_regs[r];
   endfunction

   task automatic modelStep(inout vec_t v);
      logic [4:0] rs1, rs2, rd;
      logic       acc, legal;
      alu_slot_t  cur;
      rs1 = v.instr[19:15];
      rs2 = v.instr[24:20];
      rd  = v.instr[11:7];
      v.exp_ready = !v.flush && !mBlocked(rs1, v) && !mBlocked(rs2, v) && !mBlocked(rd, v);
      acc   = v.in_valid && v.exp_ready;
      legal = (v.instr[6:0] == R);
      cur   = '{func7: 7'h0, func3: 3'h0, op1: 32'h0, op2: 32'h0, rd: 5'd0, rd_valid: 1'b0};
      if (acc && legal) begin
         cur = '{func7: v.instr[31:25], func3: v.instr[14:12], op1: mRead(rs1, v),
                 op2: mRead(rs2, v), rd: rd, rd_valid: (rd != 5'd0)};
      end
      v.exp_opcode  = (acc && legal) ? R : 7'h0;
      v.exp_illegal = acc && !legal;
      if (v.flush) begin
         v.exp_func7 = 7'h0; v.exp_func3 = 3'h0; v.exp_op1 = 32'h0;
         v.exp_op2 = 32'h0;  v.exp_rd = 5'd0;    v.exp_rd_valid = 1'b0;
      end else begin
         v.exp_func7 = m_prev.func7; v.exp_func3 = m_prev.func3; v.exp_op1 = m_prev.op1;
         v.exp_op2 = m_prev.op2;     v.exp_rd = m_prev.rd;       v.exp_rd_valid = m_prev.rd_valid;
      end
      m_prev = cur;
      if (v.wb_en && v.wb_rd != 5'd0) m_regs[v.wb_rd] = v.wb_data;
      if (v.flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
         if (v.wb_en) m_busy[v.wb_rd] = 1'b0;
         if (acc && legal && rd != 5'd0) m_busy[rd] = 1'b1;
      end
   endtask

   initial begin
      vec_t        tbl [$];
      vec_t        v;
      int          busy_list [$];
      logic [31:0] addi_x10;
      logic [6:0]  opc;

      n_checks     = 0;
      n_fails      = 0;
      rst          = 1'b1;
      flush        = 1'b0;
      wb_en        = 1'b0;
      wb_rd        = 5'd0;
      wb_data      = 32'h0;
      bus.in_valid = 1'b0;
      bus.INSTR    = 32'h0;
      addi_x10     = {12'h005, 5'd1, 3'd0, 5'd10, 7'b0010011};

      $display("[TB] reset and directed vectors");
      for (int i = 0; i < 3; i++) tbl.push_back(mkReset());
      tbl.push_back(mk(0, 32'h0, 1, 5'd1, 32'd5, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(0, 32'h0, 1, 5'd2, 32'd7, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd3, 5'd1, 5'd2), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_SUB, F3_ADD, 5'd4, 5'd1, 5'd2), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 5, 7, 5'd3, 1, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_XOR, 5'd5, 5'd1, 5'd2), 0, 5'd0, 0, 0, 1, R, F7_SUB, 3'h0, 5, 7, 5'd4, 1, 0));
      tbl.push_back(mk(0, 32'h0, 1, 5'd3, 32'd12, 0, 1, 7'h0, 7'h0, F3_XOR, 5, 7, 5'd5, 1, 0));
      tbl.push_back(mk(0, 32'h0, 1, 5'd4, 32'hFFFFFFFE, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(0, 32'h0, 1, 5'd5, 32'd2, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd6, 5'd1, 5'd2), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_AND, 5'd7, 5'd6, 5'd1), 0, 5'd0, 0, 0, 0, 7'h0, 7'h0, 3'h0, 5, 7, 5'd6, 1, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_AND, 5'd7, 5'd6, 5'd1), 0, 5'd0, 0, 0, 0, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_AND, 5'd7, 5'd6, 5'd1), 1, 5'd6, 32'h10, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(0, 32'h0, 1, 5'd7, 32'h0, 0, 1, 7'h0, 7'h0, F3_AND, 32'h10, 5, 5'd7, 1, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd8, 5'd0, 5'd2), 1, 5'd0, 32'hFF, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd9, 5'd0, 5'd0), 1, 5'd8, 32'd7, 0, 1, R, 7'h0, 3'h0, 0, 7, 5'd8, 1, 0));
      tbl.push_back(mk(0, 32'h0, 1, 5'd9, 32'h0, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd9, 1, 0));
      tbl.push_back(mk(1, addi_x10, 0, 5'd0, 0, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 1));
      tbl.push_back(mk(0, 32'h0, 0, 5'd0, 0, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd11, 5'd10, 5'd10), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd12, 5'd1, 5'd2), 0, 5'd0, 0, 1, 0, 7'h0, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd13, 5'd11, 5'd1), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(0, 32'h0, 0, 5'd0, 0, 0, 1, 7'h0, 7'h0, 3'h0, 0, 5, 5'd13, 1, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd13, 5'd1, 5'd2), 1, 5'd13, 32'd9, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd14, 5'd13, 5'd1), 0, 5'd0, 0, 0, 0, 7'h0, 7'h0, 3'h0, 5, 7, 5'd13, 1, 0));
      tbl.push_back(mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd14, 5'd13, 5'd1), 1, 5'd13, 32'd3, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0));
      tbl.push_back(mk(0, 32'h0, 0, 5'd0, 0, 0, 1, 7'h0, 7'h0, 3'h0, 3, 5, 5'd14, 1, 0));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         checkOutput(tbl[i]);
      end

      $display("[TB] reset in the middle of traffic");
      v = mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd15, 5'd1, 5'd2), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0);
      applyStimulus(v); checkOutput(v);
      v = mkReset();
      applyStimulus(v); checkOutput(v);
      v = mk(1, rtypeInstr(F7_ADD, F3_ADD, 5'd3, 5'd1, 5'd2), 0, 5'd0, 0, 0, 1, R, 7'h0, 3'h0, 0, 0, 5'd0, 0, 0);
      applyStimulus(v); checkOutput(v);
      v = mk(0, 32'h0, 0, 5'd0, 0, 0, 1, 7'h0, 7'h0, 3'h0, 0, 0, 5'd3, 1, 0);
      applyStimulus(v); checkOutput(v);

      $display("[TB] randomized traffic against the reference model");
      for (int i = 0; i < 2; i++) begin
         v = mkReset();
         applyStimulus(v); checkOutput(v);
      end
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
      m_prev = '{func7: 7'h0, func3: 3'h0, op1: 32'h0, op2: 32'h0, rd: 5'd0, rd_valid: 1'b0};

      for (int c = 0; c < 500; c++) begin
         busy_list.delete();
         for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
         v = mkReset();
         v.rst      = 1'b0;
         v.in_valid = ($urandom_range(0, 99) < 80);
         v.flush    = ($urandom_range(0, 99) < 3);
         opc        = R;
         if ($urandom_range(0, 99) < 15) begin
            opc = 7'($urandom);
            if (opc == R) opc = 7'b0010011;
         end
         v.instr = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    3'($urandom), 5'($urandom_range(0, 7)), opc};
         v.wb_en   = ($urandom_range(0, 99) < 45);
         v.wb_data = $urandom;
         if (busy_list.size() > 0 && $urandom_range(0, 99) < 70)
            v.wb_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
         else
            v.wb_rd = 5'($urandom_range(0, 7));
         modelStep(v);
         applyStimulus(v);
         checkOutput(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/operand_fetch_decode.md
# operand_fetch_decode

Decode and operand-fetch stage that sits directly upstream of the execute ALU. Accepts one 32-bit instruction per cycle over a valid/ready handshake, splits out the opcode/funct fields, reads two operands from the 32x32 integer register file (with writeback bypass), and drives the ALU inputs with the one-cycle opcode lead the ALU requires. A busy-bit scoreboard on destination registers blocks issue on read-after-write hazards until writeback completes.

## Interface
Parameters:
- XLEN, 32, operand/register width
- NREG, 32, number of architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  INSTR holds a valid instruction
- in_ready  out  1  stage can accept INSTR this cycle
- INSTR  in  32  RV32 instruction word
- flush  in  1  kill all in-flight instructions
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- OPCODE  out  7  opcode to ALU, leads FUNC/OP by one cycle
- FUNC7  out  7  funct7 to ALU
- FUNC3  out  3  funct3 to ALU
- OP1  out  XLEN  rs1 operand
- OP2  out  XLEN  rs2 operand
- RD  out  5  destination tag, aligned with OP1/OP2
- RD_VALID  out  1  RD is a real writer, aligned with OP1/OP2
- illegal  out  1  one-cycle pulse: accepted opcode is not R-type (0110011)

## Operation
- Two pipeline registers, S1 and S2; they advance every cycle unconditionally (no downstream stall).
- Accept: in_valid & in_ready. On accept, decode rs1=INSTR[19:15], rs2=INSTR[24:20], rd=INSTR[11:7], funct3=INSTR[14:12], funct7=INSTR[31:25], opcode=INSTR[6:0]; read operands; load S1 with valid=1.
- No accept: S1 loads a bubble (valid=0, all fields 0).
- S2 <= S1 every cycle.
- OPCODE driven from S1.opcode; FUNC7, FUNC3, OP1, OP2, RD, RD_VALID from S2. Bubble slots drive all-zero, so the ALU produces 0.
- Non-R-type opcode: accepted, illegal pulses the cycle after accept, slot converted to bubble (opcode 0, no scoreboard set).
- Register file read: x0 always 0. If wb_en and wb_rd==rs (rs≠0) in the accept cycle, operand takes wb_data (write-first bypass).
- Register file write: wb_en & wb_rd≠0 writes wb_data at the edge.
- Scoreboard: 32 busy bits. Set busy[rd] on accept of an R-type with rd≠0; clear busy[wb_rd] on wb_en. Same rd set and cleared in one cycle: set wins.
- in_ready = ~rst & ~busy[rs1] & ~busy[rs2] & ~busy[rd] (WAW also blocks). A busy bit being cleared by wb_en this cycle counts as not busy.
- flush: S1 and S2 become bubbles at the edge, all busy bits cleared, in_ready low that cycle (no accept). Register file untouched.

## Timing
- Reset: S1/S2 bubbles, all outputs 0, in_ready 0 during reset, all busy bits 0, all registers 0.
- Accept at edge E: OPCODE valid from E to E+1; FUNC7/FUNC3/OP1/OP2/RD/RD_VALID valid from E+1 to E+2; ALU result appears after E+2.
- Sustained throughput one instruction per cycle absent hazards.
- Hazard stall: in_ready low until the cycle wb_en targets the busy register; accept can occur in that same cycle (bypass supplies data).
- flush and accept same cycle: flush wins, instruction dropped.
- Reset mid-operation: all in-flight slots dropped, no partial outputs.

## Structure
- Shared package: opcode constants (OP_RTYPE=7'b0110011), instruction field bit positions, XLEN/NREG defaults.
- Sub-module reg_file: 32xXLEN, two combinational read ports, one write port, x0 zero, write-first bypass, synchronous reset clear.
- Scoreboard and S1/S2 registers live in the top module.

## Test plan
- Reset, then ADD x3,x1,x2 with x1=5,x2=7 preloaded via writeback -> OPCODE=0110011 one cycle, next cycle FUNC7=0,FUNC3=0,OP1=5,OP2=7,RD=3,RD_VALID=1.
- Back-to-back SUB x4,x1,x2 then XOR x5,x1,x2 -> both accepted consecutively, outputs in order, opcode lead held each cycle.
- ADD x6,x1,x2 followed by AND x7,x6,x1 -> in_ready low until wb_en with wb_rd=6, wb_data=0x10; accepted that cycle with OP1=0x10.
- Instruction reading x0 with wb_en wb_rd=0 wb_data=0xFF same cycle -> OP1=0, x0 unchanged.
- Accept opcode 0010011 -> illegal pulses one cycle, outputs stay 0, no busy bit set.
- Accept ADD x8,x1,x2 then flush next cycle -> S1/S2 bubbles, RD_VALID stays 0, busy[8] cleared, in_ready returns high.
